// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole scoring engine.
//   state_t : game-control FSM states
//   cnt_w() : bit width needed to hold a count of 0..n
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mole_popcount.sv
// Combinational population count.
//   i_vec   : input bit vector (W bits)
//   o_count : number of set bits in i_vec
module mole_popcount
  import mole_pkg::*;
#(
  parameter  int unsigned W  = 8,
  localparam int unsigned CW = cnt_w(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/mole_score_engine.sv
// Whack-a-mole scoring engine: 2-stage round evaluation pipeline, capped
// combo multiplier, optional false-hit penalty, saturating score and a
// persistent high score under an IDLE/PLAY/DRAIN/OVER game FSM.
//   clk, reset (async, active low)
//   game_start / game_end : single-cycle control pulses
//   round_valid, led_moles, hit_reg : one round of mole/hit masks
//   score, high_score, combo, hit_count : scoring state
//   score_valid : one-cycle pulse when a round has been scored
//   playing     : high while in PLAY
module mole_score_engine
  import mole_pkg::*;
#(
  parameter  int unsigned N_MOLES    = 18,
  parameter  int unsigned SCORE_W    = 11,
  parameter  int unsigned MAX_COMBO  = 5,
  parameter  int unsigned PENALTY_EN = 1,
  parameter  int unsigned PENALTY    = 1,
  localparam int unsigned CMB_W      = cnt_w(MAX_COMBO),
  localparam int unsigned HC_W       = cnt_w(N_MOLES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_start,
  input  logic               game_end,
  input  logic               round_valid,
  input  logic [N_MOLES-1:0] led_moles,
  input  logic [N_MOLES-1:0] hit_reg,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [CMB_W-1:0]   combo,
  output logic [HC_W-1:0]    hit_count,
  output logic               score_valid,
  output logic               playing
);

  localparam int unsigned SW8 = SCORE_W + 8;

  // FSM and scoring registers
  state_t             r_state;
  logic               r_drain_cnt;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [CMB_W-1:0]   r_combo;
  logic [HC_W-1:0]    r_hit_count;
  logic               r_score_valid;

  // Stage-1 pipeline registers
  logic               r_s1_valid;
  logic [HC_W-1:0]    r_s1_good;
  logic [HC_W-1:0]    r_s1_bad;
  logic               r_s1_full;
  logic               r_s1_empty;

  logic [N_MOLES-1:0] w_good_mask;
  logic [N_MOLES-1:0] w_bad_mask;
  logic [HC_W-1:0]    w_good_cnt;
  logic [HC_W-1:0]    w_bad_cnt;
  logic               w_full;
  logic               w_empty;
  logic               w_start;
  logic               w_accept;

  logic signed [SW8-1:0] w_score_ext;
  logic signed [SW8-1:0] w_pts;
  logic signed [SW8-1:0] w_pen;
  logic signed [SW8-1:0] w_sum;
  logic [SCORE_W-1:0]    w_sat;
  logic [CMB_W-1:0]      w_combo_inc;
  logic [CMB_W-1:0]      w_combo_next;

  assign w_good_mask = led_moles & hit_reg;
  assign w_bad_mask  = hit_reg & ~led_moles;
  assign w_empty     = (led_moles == '0);
  assign w_full      = !w_empty && ((led_moles & ~hit_reg) == '0);

  mole_popcount #(.W(N_MOLES)) u_pop_good (
    .i_vec   (w_good_mask),
    .o_count (w_good_cnt)
  );

  mole_popcount #(.W(N_MOLES)) u_pop_bad (
    .i_vec   (w_bad_mask),
    .o_count (w_bad_cnt)
  );

  // A start that actually (re)enters PLAY: game_end beats it in PLAY,
  // DRAIN ignores it entirely.
  assign w_start  = game_start &&
                    ((r_state == ST_IDLE) || (r_state == ST_OVER) ||
                     ((r_state == ST_PLAY) && !game_end));
  // A round in the restart cycle belongs to the abandoned game.
  assign w_accept = round_valid && (r_state == ST_PLAY) && !w_start;

  // Stage 2 arithmetic, evaluated at SCORE_W+8 signed width before clamping
  assign w_score_ext = signed'(SW8'(r_score));
  assign w_pts       = signed'(SW8'(r_s1_good) * SW8'(r_combo));
  assign w_pen       = (PENALTY_EN != 0) ? signed'(SW8'(r_s1_bad) * SW8'(PENALTY))
                                         : '0;
  assign w_sum       = w_score_ext + w_pts - w_pen;

  always_comb begin
    w_sat = w_sum[SCORE_W-1:0];
    if (w_sum[SW8-1]) begin
      w_sat = '0;
    end else if (|w_sum[SW8-2:SCORE_W]) begin
      w_sat = '1;
    end
  end

  always_comb begin
    w_combo_inc = r_combo + CMB_W'(1);
    if (r_combo >= CMB_W'(MAX_COMBO)) begin
      w_combo_inc = CMB_W'(MAX_COMBO);
    end
    if (r_s1_full) begin
      w_combo_next = w_combo_inc;
    end else if (r_s1_empty) begin
      w_combo_next = r_combo;
    end else begin
      w_combo_next = CMB_W'(1);
    end
  end

  // Stage 1: mask evaluation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_good  <= '0;
      r_s1_bad   <= '0;
      r_s1_full  <= 1'b0;
      r_s1_empty <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_good  <= w_good_cnt;
        r_s1_bad   <= w_bad_cnt;
        r_s1_full  <= w_full;
        r_s1_empty <= w_empty;
      end
    end
  end

  // FSM, stage 2 update and high score
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= 1'b0;
      r_score       <= '0;
      r_high        <= '0;
      r_combo       <= CMB_W'(1);
      r_hit_count   <= '0;
      r_score_valid <= 1'b0;
    end else begin
      r_score_valid <= 1'b0;

      if (r_s1_valid && !w_start) begin
        r_score       <= w_sat;
        r_combo       <= w_combo_next;
        r_hit_count   <= r_s1_good;
        r_score_valid <= 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (game_start) begin
            r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (game_end) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Two cycles lets the last accepted round clear stage 2
          // before the final score is compared.
          if (r_drain_cnt) begin
            r_state <= ST_OVER;
            if (r_score > r_high) begin
              r_high <= r_score;
            end
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Entering PLAY overrides any in-flight stage 2 result.
      if (w_start) begin
        r_score     <= '0;
        r_combo     <= CMB_W'(1);
        r_hit_count <= '0;
      end
    end
  end

  assign score       = r_score;
  assign high_score  = r_high;
  assign combo       = r_combo;
  assign hit_count   = r_hit_count;
  assign score_valid = r_score_valid;
  assign playing     = (r_state == ST_PLAY);

endmodule

// File: tb/tb_mole_score_engine.sv
module tb_mole_score_engine;

  localparam int SMAX = 2047;
  localparam int CMAX = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_start;
  logic        game_end;
  logic        round_valid;
  logic [17:0] led_moles;
  logic [17:0] hit_reg;

  logic [10:0] score, high_score;
  logic [2:0]  combo;
  logic [4:0]  hit_count;
  logic        score_valid, playing;

  logic [10:0] np_score, np_high_score;
  logic [2:0]  np_combo;
  logic [4:0]  np_hit_count;
  logic        np_score_valid, np_playing;

  int checks = 0;
  int errors = 0;

  mole_score_engine dut (
    .clk         (clk),
    .reset       (reset),
    .game_start  (game_start),
    .game_end    (game_end),
    .round_valid (round_valid),
    .led_moles   (led_moles),
    .hit_reg     (hit_reg),
    .score       (score),
    .high_score  (high_score),
    .combo       (combo),
    .hit_count   (hit_count),
    .score_valid (score_valid),
    .playing     (playing)
  );

  mole_score_engine #(.PENALTY_EN(0)) dut_np (
    .clk         (clk),
    .reset       (reset),
    .game_start  (game_start),
    .game_end    (game_end),
    .round_valid (round_valid),
    .led_moles   (led_moles),
    .hit_reg     (hit_reg),
    .score       (np_score),
    .high_score  (np_high_score),
    .combo       (np_combo),
    .hit_count   (np_hit_count),
    .score_valid (np_score_valid),
    .playing     (np_playing)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          restart;
    logic [17:0] led;
    logic [17:0] hit;
    int          exp_score;
    int          exp_score_np;
    int          exp_combo;
    int          exp_hc;
  } vec_t;

  typedef struct {
    int due;
    int good;
    int bad;
    bit full;
    bit empty;
  } rnd_t;

  vec_t tbl[15];
  rnd_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
  endtask

  task automatic do_round(input logic [17:0] l, input logic [17:0] h);
    round_valid = 1'b1;
    led_moles   = l;
    hit_reg     = h;
    tick();
    round_valid = 1'b0;
    led_moles   = '0;
    hit_reg     = '0;
    tick();
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > SMAX) return SMAX;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ms, ms_np, mc, mhc, n, r, mode, exp_sv;
    rnd_t e;
    logic [17:0] rl, rh;

    tbl[0]  = '{1'b1, 18'h3, 18'h3,  2,  2, 2, 2};
    tbl[1]  = '{1'b0, 18'h3, 18'h3,  6,  6, 3, 2};
    tbl[2]  = '{1'b0, 18'h3, 18'h3, 12, 12, 4, 2};
    tbl[3]  = '{1'b0, 18'h3, 18'h3, 20, 20, 5, 2};
    tbl[4]  = '{1'b0, 18'h3, 18'h3, 30, 30, 5, 2};
    tbl[5]  = '{1'b0, 18'h3, 18'h3, 40, 40, 5, 2};
    tbl[6]  = '{1'b0, 18'h7, 18'h3, 50, 50, 1, 2};
    tbl[7]  = '{1'b0, 18'h3, 18'h3, 52, 52, 2, 2};
    tbl[8]  = '{1'b0, 18'h3, 18'h3, 56, 56, 3, 2};
    tbl[9]  = '{1'b0, 18'h7, 18'h3, 62, 62, 1, 2};
    tbl[10] = '{1'b0, 18'h1, 18'h1, 63, 63, 2, 1};
    tbl[11] = '{1'b0, 18'h0, 18'h0, 63, 63, 2, 0};
    tbl[12] = '{1'b0, 18'h0, 18'h8, 62, 63, 2, 0};
    tbl[13] = '{1'b1, 18'h1, 18'h1,  1,  1, 2, 1};
    tbl[14] = '{1'b0, 18'h1, 18'h6,  0,  1, 1, 0};

    reset       = 1'b0;
    game_start  = 1'b0;
    game_end    = 1'b0;
    round_valid = 1'b0;
    led_moles   = '0;
    hit_reg     = '0;
    tick();
    tick();
    chk("rst_score", score, 0);
    chk("rst_high", high_score, 0);
    chk("rst_combo", combo, 1);
    chk("rst_hc", hit_count, 0);
    chk("rst_sv", score_valid, 0);
    chk("rst_playing", playing, 0);
    reset = 1'b1;
    tick();

    // Game 1: start+end together in IDLE -> start wins
    game_start = 1'b1;
    game_end   = 1'b1;
    tick();
    game_start = 1'b0;
    game_end   = 1'b0;
    chk("g1_playing", playing, 1);
    // Round at T, game_end at T+1: round still scored
    round_valid = 1'b1;
    led_moles   = 18'hF;
    hit_reg     = 18'hF;
    tick();
    round_valid = 1'b0;
    led_moles   = '0;
    hit_reg     = '0;
    game_end    = 1'b1;
    tick();
    game_end = 1'b0;
    chk("g1_score", score, 4);
    chk("g1_sv", score_valid, 1);
    chk("g1_drain_playing", playing, 0);
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    chk("g1_drain_ignore_start", playing, 0);
    chk("g1_high_in_drain", high_score, 0);
    tick();
    chk("g1_high_over", high_score, 4);
    chk("g1_over_playing", playing, 0);

    // Game 2: lower score, high score holds
    pulse_start();
    chk("g2_playing", playing, 1);
    chk("g2_score0", score, 0);
    chk("g2_combo1", combo, 1);
    chk("g2_high_hold", high_score, 4);
    do_round(18'h1, 18'h1);
    chk("g2_score", score, 1);
    game_start = 1'b1;
    game_end   = 1'b1;
    tick();
    game_start = 1'b0;
    game_end   = 1'b0;
    chk("g2_end_wins", playing, 0);
    chk("g2_score_kept", score, 1);
    tick();
    tick();
    chk("g2_high_unchanged", high_score, 4);
    chk("g2_score_over", score, 1);
    chk("g2_combo_over", combo, 2);

    // Table-driven rounds: combo ramp, misses, empty rounds, penalty floor
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].restart) pulse_start();
      do_round(tbl[i].led, tbl[i].hit);
      chk($sformatf("tbl%0d_score", i), score, tbl[i].exp_score);
      chk($sformatf("tbl%0d_score_np", i), np_score, tbl[i].exp_score_np);
      chk($sformatf("tbl%0d_combo", i), combo, tbl[i].exp_combo);
      chk($sformatf("tbl%0d_hc", i), hit_count, tbl[i].exp_hc);
      chk($sformatf("tbl%0d_sv", i), score_valid, 1);
    end

    // Saturation: 4 ramp rounds (180) + 20 x 90 + 12*5 = 2040, then +90
    pulse_start();
    for (int i = 0; i < 24; i++) do_round(18'h3FFFF, 18'h3FFFF);
    do_round(18'hFFF, 18'hFFF);
    chk("sat_pre_score", score, 2040);
    chk("sat_pre_combo", combo, 5);
    do_round(18'h3FFFF, 18'h3FFFF);
    chk("sat_score", score, 2047);
    chk("sat_score_np", np_score, 2047);
    chk("sat_hc", hit_count, 18);

    // Reset mid-PLAY with score 37, combo 3
    pulse_start();
    do_round(18'h1, 18'h1);
    do_round(18'h3FFFF, 18'h3FFFF);
    chk("mid_score", score, 37);
    chk("mid_combo", combo, 3);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_score", score, 0);
    chk("mid_rst_high", high_score, 0);
    chk("mid_rst_combo", combo, 1);
    chk("mid_rst_hc", hit_count, 0);
    chk("mid_rst_sv", score_valid, 0);
    chk("mid_rst_playing", playing, 0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized back-to-back rounds against a round-level model
    pulse_start();
    ms = 0; ms_np = 0; mc = 1; mhc = 0; n = 0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      mode = $urandom_range(0, 3);
      rl = 18'($urandom);
      rh = 18'($urandom);
      case (mode)
        0: rh = rl;
        1: rh = rl & rh;
        2: begin rl = '0; rh = rh & 18'($urandom); end
        default: ;
      endcase
      if (mode == 0 && $urandom_range(0, 7) == 0) begin
        rl = '0;
        rh = '0;
      end
      game_start  = (r < 2);
      round_valid = (r >= 2 && r < 77);
      led_moles   = rl;
      hit_reg     = rh;
      if (game_start) begin
        q.delete();
        ms = 0; ms_np = 0; mc = 1; mhc = 0;
      end else if (round_valid) begin
        e.due   = n + 2;
        e.good  = $countones(rl & rh);
        e.bad   = $countones(rh & ~rl);
        e.empty = (rl == 0);
        e.full  = (rl != 0) && ((rl & ~rh) == 0);
        q.push_back(e);
      end
      tick();
      n++;
      game_start  = 1'b0;
      round_valid = 1'b0;
      exp_sv = 0;
      if (q.size() > 0 && q[0].due == n) begin
        e = q.pop_front();
        ms    = clampi(ms + e.good * mc - e.bad);
        ms_np = clampi(ms_np + e.good * mc);
        if (e.full) mc = (mc + 1 > CMAX) ? CMAX : mc + 1;
        else if (!e.empty) mc = 1;
        mhc = e.good;
        exp_sv = 1;
      end
      chk($sformatf("rnd%0d_score", c), score, ms);
      chk($sformatf("rnd%0d_score_np", c), np_score, ms_np);
      chk($sformatf("rnd%0d_combo", c), combo, mc);
      chk($sformatf("rnd%0d_hc", c), hit_count, mhc);
      chk($sformatf("rnd%0d_sv", c), score_valid, exp_sv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_score_engine.md
Name: mole_score_engine

Overview:
Parametrised whack-a-mole scoring engine and the successor to the single-width bit counter. It evaluates each round's mole mask against the player's hit mask through a 2-stage pipeline. It applies a capped combo multiplier, an optional false-hit penalty, saturating arithmetic and a persistent high score, all under a game-control FSM. It sits between the mole/hit capture logic and the score display driver.

Parameters:
N_MOLES, 18, width of the mole and hit masks
SCORE_W, 11, score and high-score width
MAX_COMBO, 5, combo multiplier ceiling (>=1)
PENALTY_EN, 1, 1 = subtract PENALTY per false hit
PENALTY, 1, points deducted per false hit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
game_start  in  1  single-cycle start/restart pulse
game_end  in  1  single-cycle end pulse
round_valid  in  1  pulse; led_moles/hit_reg sampled this cycle
led_moles  in  N_MOLES  active mole mask
hit_reg  in  N_MOLES  player hit mask
score  out  SCORE_W  current game score
high_score  out  SCORE_W  best completed-game score
combo  out  $clog2(MAX_COMBO+1)  current multiplier
hit_count  out  $clog2(N_MOLES+1)  good hits of last scored round
score_valid  out  1  pulse when score updates
playing  out  1  high in PLAY

Behaviour:
- Reset (async assert, sync release): state=IDLE; score=0; high_score=0; combo=1; hit_count=0; score_valid=0; pipeline valids cleared.
- FSM states: IDLE, PLAY, DRAIN, OVER.
  - IDLE->PLAY on game_start.
  - PLAY->DRAIN on game_end.
  - DRAIN lasts exactly 2 cycles, then ->OVER.
  - OVER->PLAY on game_start.
  - game_start in PLAY restarts the game. game_start and game_end in DRAIN are ignored.
- Entering PLAY: score=0, combo=1, hit_count=0; pipeline flushed the same cycle.
- Simultaneous game_start and game_end: game_end wins in PLAY; game_start wins in IDLE/OVER.
- round_valid is accepted only in PLAY and ignored elsewhere. Rounds accepted in the last PLAY cycles complete during DRAIN.
- Stage 1 (registered, the cycle after an accepted round):
  - good = popcount(led_moles & hit_reg)
  - bad = popcount(hit_reg & ~led_moles)
  - full = (led_moles != 0) && ((led_moles & ~hit_reg) == 0)
  - empty = (led_moles == 0)
- Stage 2 (one cycle later):
  - pts = good*combo, using combo before update.
  - delta = pts - (PENALTY_EN ? bad*PENALTY : 0).
  - score = clamp(score + delta, 0, 2^SCORE_W-1), computed at SCORE_W+8 signed width.
  - combo_next = full ? min(combo+1, MAX_COMBO) : empty ? combo : 1.
  - hit_count = good; score_valid pulses for 1 cycle.
- Latency: round_valid at cycle T -> score/score_valid at T+2. Back-to-back rounds are supported every cycle with throughput 1.
- On DRAIN->OVER: if score > high_score then high_score = score. Equal scores do not update.
- score and combo hold their values through OVER and IDLE.
- Reset mid-game: everything returns to reset values immediately, including high_score.

Decomposition:
- Package mole_pkg: state enum (IDLE, PLAY, DRAIN, OVER) and a width-helper localparam function.
- Sub-module mole_popcount (parameter W): combinational popcount. It is instantiated twice, for the good mask and the bad mask.
- Remaining logic (FSM, pipeline registers, combo, saturating adder, high score) stays in one module of roughly 200 lines.

Test Plan:
(Defaults are used unless stated otherwise.)
- Reset mid-PLAY with score=37 and combo=3 -> all outputs 0, except combo=1; playing=0 with no clock edge needed.
- Combo ramp: led_moles=0x3 and hit_reg=0x3 for 6 rounds -> score 2, 6, 12, 20, 30, 40; combo caps at 5.
- Miss: at combo=3, led_moles=0x7 and hit_reg=0x3 -> +6 points, combo returns to 1, hit_count=2.
- Penalty floor: score=1, led_moles=0x1, hit_reg=0x6 -> score=0 (not negative). With PENALTY_EN=0, score stays 1.
- Saturation: score=2040, led_moles=hit_reg=0x3FFFF, combo=5 -> score=2047.
- round_valid at T with game_end at T+1 -> the round is included in score; high_score equals the final score on entering OVER. A second game with a lower score leaves high_score unchanged.
